// File: rtl/mem_access_unit_if.sv
// Request/memory bus of the memory access unit: the control-unit request side,
// the memory port, and the instruction/data registers with status strobes.
interface mem_access_unit_if;
    logic        Req;
    logic [1:0]  Kind;
    logic [31:0] PC;
    logic [31:0] ALUOut;
    logic [31:0] WData;
    logic [31:0] MemAddr;
    logic        MemWr;
    logic [31:0] MemDataIn;
    logic [31:0] MemDataOut;
    logic [31:0] Instr;
    logic [31:0] MDR;
    logic        Busy;
    logic        Done;
    logic        Misaligned;

    modport slave (
        input  Req, Kind, PC, ALUOut, WData, MemDataOut,
        output MemAddr, MemWr, MemDataIn, Instr, MDR, Busy, Done, Misaligned
    );

    modport master (
        output Req, Kind, PC, ALUOut, WData, MemDataOut,
        input  MemAddr, MemWr, MemDataIn, Instr, MDR, Busy, Done, Misaligned
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle memory access sequencer: instruction fetch, load and store through
// a 2-cycle-latency memory, with word-alignment fault detection.
module mem_access_unit (
    input  logic               Clk,
    input  logic               Reset,
    mem_access_unit_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD1  = 3'd1,
        RD2  = 3'd2,
        CAP  = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } state_t;

    localparam logic [1:0] KIND_FETCH = 2'b00;
    localparam logic [1:0] KIND_LOAD  = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;
    localparam logic [1:0] KIND_RSVD  = 2'b11;

    state_t      state_reg;
    logic [1:0]  kind_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] instr_reg;
    logic [31:0] mdr_reg;
    logic [31:0] sel_addr;

    assign sel_addr = (bus.Kind == KIND_FETCH) ? bus.PC : bus.ALUOut;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            kind_reg  <= 2'b00;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            instr_reg <= 32'd0;
            mdr_reg   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Reserved kind is dropped without latching anything
                    if (bus.Req && bus.Kind != KIND_RSVD) begin
                        kind_reg  <= bus.Kind;
                        addr_reg  <= sel_addr;
                        wdata_reg <= bus.WData;
                        if (sel_addr[1:0] != 2'b00)
                            state_reg <= ERR;
                        else if (bus.Kind == KIND_STORE)
                            state_reg <= WR;
                        else
                            state_reg <= RD1;
                    end
                end
                RD1: state_reg <= RD2;
                RD2: state_reg <= CAP;
                CAP: begin
                    if (kind_reg == KIND_FETCH)
                        instr_reg <= bus.MemDataOut;
                    else if (kind_reg == KIND_LOAD)
                        mdr_reg <= bus.MemDataOut;
                    state_reg <= DONE;
                end
                WR:      state_reg <= DONE;
                DONE:    state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Memory-side outputs decode purely from registered state and latched request
    assign bus.MemAddr    = (state_reg == RD1 || state_reg == RD2 ||
                             state_reg == CAP || state_reg == WR) ? addr_reg : 32'd0;
    assign bus.MemWr      = (state_reg == WR);
    assign bus.MemDataIn  = (state_reg == WR) ? wdata_reg : 32'd0;
    assign bus.Instr      = instr_reg;
    assign bus.MDR        = mdr_reg;
    assign bus.Busy       = (state_reg != IDLE);
    assign bus.Done       = (state_reg == DONE);
    assign bus.Misaligned = (state_reg == ERR);
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: fetch, load, store, fault, reserved kind,
// held request overlap and mid-access reset.
module tb_mem_access_unit;
    logic Clk;
    logic Reset;
    int   total;
    int   bad;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    localparam logic [31:0] JUNK = 32'hBAD0BAD0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Reset = 1'b1;
        bus.Req = 1'b0;
        bus.Kind = 2'b00;
        bus.PC = 32'd0;
        bus.ALUOut = 32'd0;
        bus.WData = 32'd0;
        bus.MemDataOut = JUNK;
        tick();
        tick();
        chk("rst_busy",  {31'd0, bus.Busy}, 32'd0);
        chk("rst_instr", bus.Instr, 32'd0);
        chk("rst_mdr",   bus.MDR, 32'd0);
        chk("rst_addr",  bus.MemAddr, 32'd0);
        chk("rst_wr",    {31'd0, bus.MemWr}, 32'd0);
        chk("rst_din",   bus.MemDataIn, 32'd0);
        chk("rst_done",  {31'd0, bus.Done}, 32'd0);
        chk("rst_mis",   {31'd0, bus.Misaligned}, 32'd0);
        Reset = 1'b0;
        tick();

        // Fetch
        bus.PC = 32'h00000010; bus.ALUOut = 32'h00000300; bus.Kind = 2'b00; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0; bus.PC = 32'h00000FF0;
        chk("f_rd1_busy", {31'd0, bus.Busy}, 32'd1);
        chk("f_rd1_addr", bus.MemAddr, 32'h10);
        tick();
        chk("f_rd2_addr", bus.MemAddr, 32'h10);
        tick();
        bus.MemDataOut = 32'h8C430004;
        chk("f_cap_addr", bus.MemAddr, 32'h10);
        chk("f_cap_done", {31'd0, bus.Done}, 32'd0);
        chk("f_cap_wr",   {31'd0, bus.MemWr}, 32'd0);
        tick();
        bus.MemDataOut = JUNK;
        chk("f_done",      {31'd0, bus.Done}, 32'd1);
        chk("f_instr",     bus.Instr, 32'h8C430004);
        chk("f_mdr",       bus.MDR, 32'd0);
        chk("f_done_addr", bus.MemAddr, 32'd0);
        tick();
        chk("f_idle_busy", {31'd0, bus.Busy}, 32'd0);
        chk("f_idle_done", {31'd0, bus.Done}, 32'd0);

        // Load
        bus.ALUOut = 32'h00000100; bus.PC = 32'h00000044; bus.Kind = 2'b01; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0; bus.Kind = 2'b10; bus.ALUOut = 32'h00000555;
        chk("l_rd1_addr", bus.MemAddr, 32'h100);
        tick();
        chk("l_rd2_addr", bus.MemAddr, 32'h100);
        tick();
        bus.MemDataOut = 32'hDEADBEEF;
        chk("l_cap_addr", bus.MemAddr, 32'h100);
        chk("l_cap_wr",   {31'd0, bus.MemWr}, 32'd0);
        tick();
        bus.MemDataOut = JUNK;
        chk("l_done",  {31'd0, bus.Done}, 32'd1);
        chk("l_mdr",   bus.MDR, 32'hDEADBEEF);
        chk("l_instr", bus.Instr, 32'h8C430004);
        tick();
        chk("l_idle_busy", {31'd0, bus.Busy}, 32'd0);

        // Store
        bus.ALUOut = 32'h00000020; bus.WData = 32'h12345678; bus.Kind = 2'b10; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0; bus.WData = 32'hFFFFFFFF; bus.ALUOut = 32'h00000040;
        chk("s_wr",      {31'd0, bus.MemWr}, 32'd1);
        chk("s_wr_addr", bus.MemAddr, 32'h20);
        chk("s_wr_din",  bus.MemDataIn, 32'h12345678);
        chk("s_wr_done", {31'd0, bus.Done}, 32'd0);
        tick();
        chk("s_done",      {31'd0, bus.Done}, 32'd1);
        chk("s_done_wr",   {31'd0, bus.MemWr}, 32'd0);
        chk("s_done_addr", bus.MemAddr, 32'd0);
        chk("s_mdr_hold",  bus.MDR, 32'hDEADBEEF);
        tick();
        chk("s_idle_busy", {31'd0, bus.Busy}, 32'd0);
        chk("s_idle_done", {31'd0, bus.Done}, 32'd0);

        // Misaligned store
        bus.ALUOut = 32'h00000102; bus.Kind = 2'b10; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0;
        chk("e_mis",  {31'd0, bus.Misaligned}, 32'd1);
        chk("e_wr",   {31'd0, bus.MemWr}, 32'd0);
        chk("e_done", {31'd0, bus.Done}, 32'd0);
        chk("e_busy", {31'd0, bus.Busy}, 32'd1);
        chk("e_addr", bus.MemAddr, 32'd0);
        tick();
        chk("e_mis_clr", {31'd0, bus.Misaligned}, 32'd0);
        chk("e_idle",    {31'd0, bus.Busy}, 32'd0);
        chk("e_nodone",  {31'd0, bus.Done}, 32'd0);
        chk("e_instr",   bus.Instr, 32'h8C430004);

        // Reserved kind
        bus.Kind = 2'b11; bus.ALUOut = 32'h00000200; bus.PC = 32'h00000080; bus.Req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("r_busy%0d", i), {31'd0, bus.Busy}, 32'd0);
            chk($sformatf("r_addr%0d", i), bus.MemAddr, 32'd0);
            chk($sformatf("r_wr%0d", i),   {31'd0, bus.MemWr}, 32'd0);
        end
        chk("r_instr", bus.Instr, 32'h8C430004);
        chk("r_mdr",   bus.MDR, 32'hDEADBEEF);

        // Req held through a fetch: re-accepted only after DONE returns to IDLE
        bus.Kind = 2'b00; bus.PC = 32'h00000040;
        tick();
        chk("o_rd1_addr", bus.MemAddr, 32'h40);
        tick();
        tick();
        bus.MemDataOut = 32'h11111111;
        chk("o_cap_busy", {31'd0, bus.Busy}, 32'd1);
        tick();
        bus.MemDataOut = JUNK;
        chk("o_done",  {31'd0, bus.Done}, 32'd1);
        chk("o_instr", bus.Instr, 32'h11111111);
        tick();
        bus.PC = 32'h00000044;
        chk("o_idle_busy", {31'd0, bus.Busy}, 32'd0);
        tick();
        bus.Req = 1'b0;
        chk("o_reacc_busy", {31'd0, bus.Busy}, 32'd1);
        chk("o_reacc_addr", bus.MemAddr, 32'h44);
        tick();
        chk("o_rd2_addr", bus.MemAddr, 32'h44);

        // Reset during RD2
        #2;
        Reset = 1'b1;
        #1;
        chk("x_busy",  {31'd0, bus.Busy}, 32'd0);
        chk("x_instr", bus.Instr, 32'd0);
        chk("x_mdr",   bus.MDR, 32'd0);
        chk("x_addr",  bus.MemAddr, 32'd0);
        tick();
        chk("x_hold_busy", {31'd0, bus.Busy}, 32'd0);
        Reset = 1'b0;

        // First request after reset is accepted on the first edge
        bus.ALUOut = 32'h00000200; bus.Kind = 2'b01; bus.Req = 1'b1;
        tick();
        bus.Req = 1'b0;
        chk("p_busy", {31'd0, bus.Busy}, 32'd1);
        chk("p_addr", bus.MemAddr, 32'h200);
        tick();
        tick();
        bus.MemDataOut = 32'hCAFEF00D;
        tick();
        bus.MemDataOut = JUNK;
        chk("p_done",  {31'd0, bus.Done}, 32'd1);
        chk("p_mdr",   bus.MDR, 32'hCAFEF00D);
        chk("p_instr", bus.Instr, 32'd0);
        tick();
        chk("p_idle", {31'd0, bus.Busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
